// File: rtl/deserializer.sv
// Serial-to-parallel converter: packs COUNT WIDTH-bit words into one output word under valid/ready.
// Define DESER_FLUSH_EN to add in_last/out_count for early-closed (short) groups.
module deserializer #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*COUNT-1:0] out
`ifdef DESER_FLUSH_EN
  ,
  input  logic                   in_last,
  output logic [$clog2(COUNT+1)-1:0] out_count
`endif
);

  localparam int CNT_W = $clog2(COUNT);
  localparam int OC_W  = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                 state, next_state;
  logic [CNT_W-1:0]       cnt, next_cnt;
  logic [CNT_W-1:0]       slot;
  logic [WIDTH*COUNT-1:0] data, next_data;
  logic                   accept, close;
`ifdef DESER_FLUSH_EN
  logic [OC_W-1:0]        fill, next_fill;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
      data  <= '0;
`ifdef DESER_FLUSH_EN
      fill  <= '0;
`endif
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      data  <= next_data;
`ifdef DESER_FLUSH_EN
      fill  <= next_fill;
`endif
    end
  end

  // A word accepted while FULL is necessarily paired with a drain and opens the next group at slot 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_data  = data;
`ifdef DESER_FLUSH_EN
    next_fill  = fill;
`endif
    accept = in_valid && in_ready;
    slot   = (state == FULL) ? '0 : cnt;
`ifdef DESER_FLUSH_EN
    close  = (slot == LAST_IDX) || in_last;
`else
    close  = (slot == LAST_IDX);
`endif

    if (state == FULL && out_ready) begin
      next_state = FILL;
      next_cnt   = '0;
    end

    if (accept) begin
      if (slot == '0) next_data = '0;
      next_data[slot*WIDTH +: WIDTH] = in;
      if (close) begin
        next_state = FULL;
        next_cnt   = '0;
`ifdef DESER_FLUSH_EN
        next_fill  = OC_W'(slot) + OC_W'(1);
`endif
      end else begin
        next_state = FILL;
        next_cnt   = slot + 1'b1;
      end
    end
  end

  // in_ready depends only on state and out_ready, so a stalled consumer blocks input the same cycle.
  always_comb begin
    in_ready  = !reset && ((state == FILL) || out_ready);
    out_valid = (state == FULL);
    out       = data;
`ifdef DESER_FLUSH_EN
    out_count = fill;
`endif
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (WIDTH=8, COUNT=4) with a scoreboard of expected groups.
// Flush-mode checks compile in only when DESER_FLUSH_EN is defined.
module tb_deserializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
`ifdef DESER_FLUSH_EN
  logic        in_last;
  logic [2:0]  out_count;
`endif

  typedef struct {
    logic [31:0] data;
    int          n;
  } grp_t;

  grp_t        q[$];
  logic [31:0] grp;
  int          gcnt;
  int          tests;
  int          fails;
  int          drains;
  logic        last_accept;

  deserializer #(.WIDTH(8), .COUNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef DESER_FLUSH_EN
    ,
    .in_last   (in_last),
    .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus, checks outputs against the scoreboard head, then updates the model.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic l);
    logic exp_valid;
    logic acc;
    logic drn;
    logic use_last;
    grp_t g;
    @(negedge clk);
    in_valid  = v;
    in        = d;
    out_ready = r;
`ifdef DESER_FLUSH_EN
    in_last   = l;
    use_last  = l;
`else
    use_last  = 1'b0;
`endif
    #1;
    exp_valid = (q.size() != 0);
    tests++;
    if (out_valid !== exp_valid) begin
      fails++;
      $display("[TB] FAIL out_valid: got %b expected %b", out_valid, exp_valid);
    end
    tests++;
    if (in_ready !== (!exp_valid || r)) begin
      fails++;
      $display("[TB] FAIL in_ready: got %b expected %b", in_ready, (!exp_valid || r));
    end
    if (exp_valid) begin
      tests++;
      if (out !== q[0].data) begin
        fails++;
        $display("[TB] FAIL out_data: got %h expected %h", out, q[0].data);
      end
`ifdef DESER_FLUSH_EN
      tests++;
      if (out_count !== 3'(q[0].n)) begin
        fails++;
        $display("[TB] FAIL out_count: got %0d expected %0d", out_count, q[0].n);
      end
`endif
    end
    acc = v && in_ready;
    drn = out_valid && r;
    last_accept = acc;
    if (drn) begin
      drains++;
      if (q.size() != 0) void'(q.pop_front());
    end
    if (acc) begin
      if (gcnt == 0) grp = '0;
      grp[gcnt*8 +: 8] = d;
      gcnt++;
      if (gcnt == 4 || use_last) begin
        g.data = grp;
        g.n    = gcnt;
        q.push_back(g);
        gcnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b0;
`ifdef DESER_FLUSH_EN
    in_last   = 1'b0;
`endif
    @(negedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_in_ready_high: got %b expected 0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || out !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got valid=%b out=%h expected valid=0 out=00000000", out_valid, out);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_in_ready_low: got %b expected 1", in_ready);
    end
`ifdef DESER_FLUSH_EN
    tests++;
    if (out_count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL reset_out_count: got %0d expected 0", out_count);
    end
`endif
    q.delete();
    gcnt = 0;
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out !== 32'h44332211) begin
      fails++;
      $display("[TB] FAIL basic_group: got valid=%b out=%h expected valid=1 out=44332211", out_valid, out);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_after_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stream();
    int stalls;
    int d0;
    stalls = 0;
    d0 = drains;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      if (!last_accept) stalls++;
      if (i == 5) begin
        tests++;
        if (out !== 32'h04030201) begin
          fails++;
          $display("[TB] FAIL stream_group1: got %h expected 04030201", out);
        end
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out !== 32'h08070605) begin
      fails++;
      $display("[TB] FAIL stream_group2: got valid=%b out=%h expected valid=1 out=08070605", out_valid, out);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (stalls != 0 || drains - d0 != 2) begin
      fails++;
      $display("[TB] FAIL stream_throughput: got stalls=%0d drains=%0d expected stalls=0 drains=2", stalls, drains - d0);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
      tests++;
      if (in_ready !== 1'b0 || out !== 32'hA4A3A2A1) begin
        fails++;
        $display("[TB] FAIL backpressure_hold: got in_ready=%b out=%h expected in_ready=0 out=a4a3a2a1", in_ready, out);
      end
    end
    applyStimulus(1'b1, 8'hB1, 1'b1, 1'b0);
    tests++;
    if (last_accept !== 1'b1) begin
      fails++;
      $display("[TB] FAIL backpressure_release: got accept=%b expected 1", last_accept);
    end
    applyStimulus(1'b1, 8'hB2, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hB3, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hB4, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (out !== 32'hB4B3B2B1) begin
      fails++;
      $display("[TB] FAIL backpressure_next: got %h expected b4b3b2b1", out);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out !== 32'h0) begin
      fails++;
      $display("[TB] FAIL midreset_clear: got valid=%b out=%h expected valid=0 out=00000000", out_valid, out);
    end
    q.delete();
    gcnt = 0;
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out !== 32'h88776655) begin
      fails++;
      $display("[TB] FAIL midreset_group: got valid=%b out=%h expected valid=1 out=88776655", out_valid, out);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

`ifdef DESER_FLUSH_EN
  task automatic test_flush();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out !== 32'h00002211 || out_count !== 3'd2) begin
      fails++;
      $display("[TB] FAIL flush_short: got valid=%b out=%h count=%0d expected valid=1 out=00002211 count=2", out_valid, out, out_count);
    end
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (out !== 32'h66554433 || out_count !== 3'd4) begin
      fails++;
      $display("[TB] FAIL flush_full: got out=%h count=%0d expected out=66554433 count=4", out, out_count);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    int guard;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0));
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL random_drain: got %0d groups pending expected 0", q.size());
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    drains      = 0;
    gcnt        = 0;
    grp         = '0;
    last_accept = 1'b0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in          = '0;
    out_ready   = 1'b0;
`ifdef DESER_FLUSH_EN
    in_last     = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stream();
    test_back_to_back();
    test_mid_reset();
`ifdef DESER_FLUSH_EN
    test_flush();
`endif
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Sequential serial-to-parallel converter: accepts a stream of WIDTH-bit words over a valid/ready handshake and packs COUNT consecutive words into one WIDTH*COUNT-bit output word, also under valid/ready. It is the inverse of the Mux/serializer direction: where a mux funnels several sources onto one wire, this block spreads one wire across several lanes over time. It sits between narrow producers and wide consumers in generated pipelines.

## Interface
- WIDTH, 32, bits per input word (>= 1)
- COUNT, 4, input words per output word (>= 2)
- clk  input  1  clock, all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  producer has a word on `in`
- in_ready  output  1  block accepts `in` this cycle
- in  input  WIDTH  input word
- out_valid  output  1  `out` holds a complete group
- out_ready  input  1  consumer takes `out` this cycle
- out  output  WIDTH*COUNT  packed group; word k at bits [k*WIDTH +: WIDTH]
- in_last  input  1  (DESER_FLUSH_EN only) close group after this word
- out_count  output  $clog2(COUNT+1)  (DESER_FLUSH_EN only) valid words in `out`

## Operation
- Accept = in_valid && in_ready; drain = out_valid && out_ready.
- Internal fill counter `cnt`, range 0..COUNT-1, width $clog2(COUNT).
- States: FILL (out_valid=0), FULL (out_valid=1).
- FILL: on accept, word written to slot `cnt`; if cnt==COUNT-1, cnt<=0, go FULL; else cnt<=cnt+1.
- Accept with cnt==0 starts a new group: slot 0 <= in, slots 1..COUNT-1 <= 0 same cycle.
- FULL: `out` held stable until drain. in_ready = out_ready (pass-through).
- FULL with drain and accept same cycle: group leaves, incoming word becomes slot 0 of next group (others zeroed), cnt<=1, state FILL. Drain without accept: FILL, cnt=0.
- FULL without drain: no accept, state and `out` unchanged.
- in_ready = (state==FILL) || out_ready; combinational from out_ready only, never from in_valid.
- out_valid, out are registered; no combinational path in→out.
- Reset mid-group: partial group discarded, no output produced for it.

## Timing
- Reset values: out_valid=0, out=0, cnt=0, state FILL, out_count=0; in_ready=1 once reset is low (0 while reset high).
- Latency: out_valid rises the cycle after the COUNT-th word is accepted.
- Throughput: one input word per cycle sustained when consumer drains in the cycle out_valid is high; output every COUNT cycles, no bubble.
- Once out_valid=1 it stays 1 with `out` unchanged until drain (AXI-style stability).
- Back-pressure: if out_ready=0 while FULL, in_ready=0 immediately, same cycle.

## Configuration
- Macro: DESER_FLUSH_EN.
- Defined: in_last and out_count ports exist. Accept with in_last=1 closes group immediately regardless of cnt: go FULL, cnt<=0, out_count = words in group (1..COUNT); unfilled slots read 0. Full groups report out_count=COUNT. in_last on the COUNT-th word is equivalent to normal completion.
- Undefined: ports absent, groups always exactly COUNT words, no out_count logic.

## Test plan
- WIDTH=8, COUNT=4, out_ready=1; feed 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle later out_valid=1, out=0x44332211; then out_valid=0.
- Continuous stream 0x01..0x08, out_ready=1 -> out=0x04030201 then 0x08070605, in_ready never drops, no bubbles.
- Complete group 0xA1..0xA4, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out stable at 0xA4A3A2A1 all 5 cycles; on out_ready=1 next word 0xB1 accepted same cycle as slot 0.
- Accept 0x11,0x22, assert reset one cycle, then feed 0x55..0x88 -> out=0x88776655, no trace of 0x11/0x22; out=0, out_valid=0 right after reset.
- DESER_FLUSH_EN: feed 0x11, 0x22 with in_last=1 -> out_valid=1, out=0x00002211, out_count=2; next group 0x33..0x66 -> out_count=4.
- Random in_valid/out_ready (10k cycles) vs scoreboard -> every input word appears exactly once, in order, in the correct slot.
